qlinear_tile_controller: RTL and testbench

- Multi-lane successor to the single-MAC layer sequencer. Computes y = requant(W·x) for a quantized linear layer, NUM_LANES output neurons per tile in parallel.
- Layer dimensions and requant shift are set per run, up to the compile-time maxima.
- Sits between the token BRAM, a lane-packed weight BRAM and the result BRAM. Started by the top-level layer scheduler.

---
 rtl/qlinear_pkg.sv | 39 +++
 rtl/qlinear_tile_controller_if.sv | 43 ++++
 rtl/qlinear_mac_lane.sv | 26 ++
 rtl/qlinear_tile_controller.sv | 176 +++++++++++++++++
 tb/tb_qlinear_tile_controller.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qlinear_pkg.sv
// Shared types and arithmetic helpers for the quantized linear tile controller.
package qlinear_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    // Requant math runs at a fixed wide width so rounding can never wrap.
    localparam int unsigned RQ_W    = 64;
    localparam int unsigned SHIFT_W = 5;

    // LSB of lane 'lane' inside a lane-packed word.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
        return lane * dw;
    endfunction

    // Round-half-up arithmetic right shift, then saturate to a dw-bit signed range.
    function automatic logic signed [RQ_W-1:0] requant(
        input logic signed [RQ_W-1:0] acc,
        input logic [SHIFT_W-1:0]     shift,
        input int unsigned            dw
    );
        logic signed [RQ_W-1:0] rnd;
        logic signed [RQ_W-1:0] r;
        logic signed [RQ_W-1:0] hi;
        rnd = '0;
        if (shift != '0) rnd = signed'(RQ_W'(1) << (shift - SHIFT_W'(1)));
        r  = (acc + rnd) >>> shift;
        hi = signed'((RQ_W'(1) << (dw - 1)) - RQ_W'(1));
        if (r > hi)       r = hi;
        else if (r < ~hi) r = ~hi;
        return r;
    endfunction

endpackage

// File: rtl/qlinear_tile_controller_if.sv
// Scheduler handshake plus token/weight read and result write buses of the tile controller.
interface qlinear_tile_controller_if
    import qlinear_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned MAX_IN_LEN  = 512,
    parameter int unsigned MAX_OUT_LEN = 512,
    parameter int unsigned ADDR_WIDTH  = 10
);
    localparam int unsigned IN_LEN_W  = $clog2(MAX_IN_LEN) + 1;
    localparam int unsigned OUT_LEN_W = $clog2(MAX_OUT_LEN) + 1;

    logic                            start;
    logic [IN_LEN_W-1:0]             cfg_in_len;
    logic [OUT_LEN_W-1:0]            cfg_out_len;
    logic [SHIFT_W-1:0]              cfg_shift;
    logic                            busy;
    logic                            done;
    logic                            tok_rd_en;
    logic [ADDR_WIDTH-1:0]           tok_rd_addr;
    logic [DATA_WIDTH-1:0]           tok_rd_data;
    logic                            wgt_rd_en;
    logic [ADDR_WIDTH-1:0]           wgt_rd_addr;
    logic [NUM_LANES*DATA_WIDTH-1:0] wgt_rd_data;
    logic                            res_wr_en;
    logic [ADDR_WIDTH-1:0]           res_wr_addr;
    logic [NUM_LANES*DATA_WIDTH-1:0] res_wr_data;
    logic [NUM_LANES-1:0]            res_wr_mask;

    modport master (
        input  start, cfg_in_len, cfg_out_len, cfg_shift, tok_rd_data, wgt_rd_data,
        output busy, done, tok_rd_en, tok_rd_addr, wgt_rd_en, wgt_rd_addr,
               res_wr_en, res_wr_addr, res_wr_data, res_wr_mask
    );

    modport slave (
        output start, cfg_in_len, cfg_out_len, cfg_shift, tok_rd_data, wgt_rd_data,
        input  busy, done, tok_rd_en, tok_rd_addr, wgt_rd_en, wgt_rd_addr,
               res_wr_en, res_wr_addr, res_wr_data, res_wr_mask
    );

endinterface

// File: rtl/qlinear_mac_lane.sv
// One signed multiply-accumulate lane with synchronous clear and enable.
module qlinear_mac_lane #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 41
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] tok,
    input  logic signed [DATA_WIDTH-1:0] wgt,
    output logic signed [ACC_WIDTH-1:0]  acc
);
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;

    logic signed [PROD_W-1:0] prod;

    assign prod = PROD_W'(tok) * PROD_W'(wgt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= acc + ACC_WIDTH'(prod);
    end

endmodule

// File: rtl/qlinear_tile_controller.sv
// Tiled y = requant(W*x) sequencer, NUM_LANES neurons per tile.
// Define QLINEAR_RELU_EN to clamp negative accumulators to zero before requant.
module qlinear_tile_controller
    import qlinear_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned MAX_IN_LEN  = 512,
    parameter int unsigned MAX_OUT_LEN = 512,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned ACC_WIDTH   = 2 * DATA_WIDTH + $clog2(MAX_IN_LEN),
    parameter int unsigned RD_LATENCY  = 1
) (
    input logic                         clk,
    input logic                         rst,
    qlinear_tile_controller_if.master   bus
);
    localparam int unsigned IN_LEN_W  = $clog2(MAX_IN_LEN) + 1;
    localparam int unsigned OUT_LEN_W = $clog2(MAX_OUT_LEN) + 1;
    localparam int unsigned BASE_W    = OUT_LEN_W + 1;
    localparam int unsigned LAT_W     = $clog2(RD_LATENCY + 1);

    state_t                  state;
    logic [IN_LEN_W-1:0]     in_len;
    logic [OUT_LEN_W-1:0]    out_len;
    logic [SHIFT_W-1:0]      shift;
    logic [IN_LEN_W-1:0]     elem;
    logic [OUT_LEN_W-1:0]    tile;
    logic [BASE_W-1:0]       tile_base;
    logic [LAT_W-1:0]        drain_cnt;
    logic [RD_LATENCY-1:0]   vld;
    logic                    acc_clr;
    logic                    acc_en;
    logic [NUM_LANES-1:0]    lane_mask_c;
    logic signed [ACC_WIDTH-1:0] acc [NUM_LANES];

    assign acc_clr = (state == S_FETCH) && (elem == '0);
    assign acc_en  = vld[RD_LATENCY-1];

    always_comb begin
        lane_mask_c = '0;
        for (int l = 0; l < NUM_LANES; l++)
            lane_mask_c[l] = (tile_base + BASE_W'(l)) < BASE_W'(out_len);
    end

    // Read-valid pipeline mirrors the BRAM latency so products land with their data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= bus.tok_rd_en;
            for (int i = 1; i < RD_LATENCY; i++) vld[i] <= vld[i-1];
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic signed [RQ_W-1:0] acc_ext;
        logic signed [RQ_W-1:0] rq;

        qlinear_mac_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk(clk),
            .rst(rst),
            .clr(acc_clr),
            .en (acc_en),
            .tok(bus.tok_rd_data),
            .wgt(bus.wgt_rd_data[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH]),
            .acc(acc[l])
        );

`ifdef QLINEAR_RELU_EN
        assign acc_ext = acc[l][ACC_WIDTH-1] ? '0 : RQ_W'(acc[l]);
`else
        assign acc_ext = RQ_W'(acc[l]);
`endif
        assign rq = requant(acc_ext, shift, DATA_WIDTH);
        assign bus.res_wr_data[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH] =
            bus.res_wr_mask[l] ? DATA_WIDTH'(rq) : '0;
    end

    // Sequencer: one FETCH/DRAIN/WRITE pass per tile; the weight address simply
    // keeps counting across tiles because it equals tile*in_len + elem.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            in_len          <= '0;
            out_len         <= '0;
            shift           <= '0;
            elem            <= '0;
            tile            <= '0;
            tile_base       <= '0;
            drain_cnt       <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.tok_rd_en   <= 1'b0;
            bus.tok_rd_addr <= '0;
            bus.wgt_rd_en   <= 1'b0;
            bus.wgt_rd_addr <= '0;
            bus.res_wr_en   <= 1'b0;
            bus.res_wr_addr <= '0;
            bus.res_wr_mask <= '0;
        end else begin
            bus.done        <= 1'b0;
            bus.res_wr_en   <= 1'b0;
            bus.res_wr_mask <= '0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        in_len          <= bus.cfg_in_len;
                        out_len         <= bus.cfg_out_len;
                        shift           <= bus.cfg_shift;
                        elem            <= '0;
                        tile            <= '0;
                        tile_base       <= '0;
                        bus.busy        <= 1'b1;
                        bus.tok_rd_addr <= '0;
                        bus.wgt_rd_addr <= '0;
                        if (bus.cfg_in_len == '0 || bus.cfg_out_len == '0) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state         <= S_FETCH;
                            bus.tok_rd_en <= 1'b1;
                            bus.wgt_rd_en <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (elem == in_len - IN_LEN_W'(1)) begin
                        state         <= S_DRAIN;
                        drain_cnt     <= '0;
                        bus.tok_rd_en <= 1'b0;
                        bus.wgt_rd_en <= 1'b0;
                    end else begin
                        elem            <= elem + IN_LEN_W'(1);
                        bus.tok_rd_addr <= ADDR_WIDTH'(elem + IN_LEN_W'(1));
                        bus.wgt_rd_addr <= bus.wgt_rd_addr + ADDR_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == LAT_W'(RD_LATENCY - 1)) begin
                        state           <= S_WRITE;
                        bus.res_wr_en   <= 1'b1;
                        bus.res_wr_addr <= ADDR_WIDTH'(tile);
                        bus.res_wr_mask <= lane_mask_c;
                    end else begin
                        drain_cnt <= drain_cnt + LAT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (tile_base + BASE_W'(NUM_LANES) >= BASE_W'(out_len)) begin
                        state    <= S_DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state           <= S_FETCH;
                        tile            <= tile + OUT_LEN_W'(1);
                        tile_base       <= tile_base + BASE_W'(NUM_LANES);
                        elem            <= '0;
                        bus.tok_rd_en   <= 1'b1;
                        bus.wgt_rd_en   <= 1'b1;
                        bus.tok_rd_addr <= '0;
                        bus.wgt_rd_addr <= bus.wgt_rd_addr + ADDR_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qlinear_tile_controller.sv
// Scoreboard bench for qlinear_tile_controller: neuron-level reference model feeds
// expected read/write queues, a negedge monitor pops and compares.
module tb_qlinear_tile_controller;
    localparam int DW   = 16;
    localparam int NL   = 4;
    localparam int AW   = 10;
    localparam int RDL  = 1;
    localparam int MAXN = 16;
    localparam int MAXE = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    qlinear_tile_controller_if #(
        .DATA_WIDTH(DW), .NUM_LANES(NL), .MAX_IN_LEN(512), .MAX_OUT_LEN(512), .ADDR_WIDTH(AW)
    ) bus ();

    qlinear_tile_controller #(
        .DATA_WIDTH(DW), .NUM_LANES(NL), .MAX_IN_LEN(512), .MAX_OUT_LEN(512),
        .ADDR_WIDTH(AW), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [AW-1:0]    addr;
        logic [NL-1:0]    mask;
        logic [NL*DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [AW-1:0] tok;
        logic [AW-1:0] wgt;
    } rd_t;

    wr_t exp_wr[$];
    rd_t exp_rd[$];
    wr_t mon_wr;
    rd_t mon_rd;
    int  errors = 0;
    int  checks = 0;

    int               xv [MAXE];
    int               wv [MAXN][MAXE];
    logic [DW-1:0]    tok_mem [1024];
    logic [NL*DW-1:0] wgt_mem [1024];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen but not expected", name);
    endtask

    // Synchronous BRAMs, one cycle read latency.
    always @(posedge clk) begin
        if (bus.tok_rd_en) bus.tok_rd_data <= tok_mem[bus.tok_rd_addr];
        if (bus.wgt_rd_en) bus.wgt_rd_data <= wgt_mem[bus.wgt_rd_addr];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tok_rd_en || bus.wgt_rd_en) begin
                if (exp_rd.size() == 0) flag("unexpected_read");
                else begin
                    mon_rd = exp_rd.pop_front();
                    chk("rd_en_pair", 64'({bus.tok_rd_en, bus.wgt_rd_en}), 64'(2'b11));
                    chk("tok_rd_addr", 64'(bus.tok_rd_addr), 64'(mon_rd.tok));
                    chk("wgt_rd_addr", 64'(bus.wgt_rd_addr), 64'(mon_rd.wgt));
                end
            end
            if (bus.res_wr_en) begin
                if (exp_wr.size() == 0) flag("unexpected_write");
                else begin
                    mon_wr = exp_wr.pop_front();
                    chk("res_wr_addr", 64'(bus.res_wr_addr), 64'(mon_wr.addr));
                    chk("res_wr_mask", 64'(bus.res_wr_mask), 64'(mon_wr.mask));
                    chk("res_wr_data", 64'(bus.res_wr_data), 64'(mon_wr.data));
                end
            end
        end
    end

    // Neuron n result: dot product, optional ReLU, round-half-up divide, saturate.
    function automatic longint ref_neuron(input int n, input int in_len, input int sh);
        longint acc, num, den, q;
        acc = 0;
        for (int e = 0; e < in_len; e++) acc += longint'(xv[e]) * longint'(wv[n][e]);
`ifdef QLINEAR_RELU_EN
        if (acc < 0) acc = 0;
`endif
        q = acc;
        if (sh > 0) begin
            den = longint'(1) << sh;
            num = acc + den / 2;
            q   = num / den;
            if ((num % den) != 0 && num < 0) q = q - 1;
        end
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    task automatic load_and_expect(input int in_len, input int out_len, input int sh);
        int  tiles;
        wr_t w;
        rd_t r;
        logic [NL*DW-1:0] word;
        tiles = (out_len + NL - 1) / NL;
        for (int e = 0; e < in_len; e++) tok_mem[e] = DW'(xv[e]);
        for (int t = 0; t < tiles; t++)
            for (int e = 0; e < in_len; e++) begin
                for (int l = 0; l < NL; l++)
                    word[l*DW +: DW] = (t*NL + l < out_len) ? DW'(wv[t*NL+l][e]) : DW'($urandom);
                wgt_mem[t*in_len + e] = word;
            end
        if (in_len == 0 || out_len == 0) return;
        for (int t = 0; t < tiles; t++) begin
            for (int e = 0; e < in_len; e++) begin
                r.tok = AW'(e);
                r.wgt = AW'(t*in_len + e);
                exp_rd.push_back(r);
            end
            w.addr = AW'(t);
            w.mask = '0;
            w.data = '0;
            for (int l = 0; l < NL; l++)
                if (t*NL + l < out_len) begin
                    w.mask[l] = 1'b1;
                    w.data[l*DW +: DW] = DW'(ref_neuron(t*NL + l, in_len, sh));
                end
            exp_wr.push_back(w);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},      64'(bus.busy), 64'(0));
        chk({tag, "_done"},      64'(bus.done), 64'(0));
        chk({tag, "_rd_en"},     64'({bus.tok_rd_en, bus.wgt_rd_en}), 64'(0));
        chk({tag, "_rd_addr"},   64'({bus.tok_rd_addr, bus.wgt_rd_addr}), 64'(0));
        chk({tag, "_wr_en"},     64'(bus.res_wr_en), 64'(0));
        chk({tag, "_wr_addr"},   64'(bus.res_wr_addr), 64'(0));
        chk({tag, "_wr_mask"},   64'(bus.res_wr_mask), 64'(0));
        chk({tag, "_wr_data"},   64'(bus.res_wr_data), 64'(0));
    endtask

    task automatic run(input int in_len, input int out_len, input int sh,
                       input int abort_at, input bit poke);
        int total, n;
        bit seen;
        load_and_expect(in_len, out_len, sh);
        total = (in_len == 0 || out_len == 0) ? 1
              : ((out_len + NL - 1) / NL) * (in_len + RDL + 1) + 1;
        bus.cfg_in_len  = 10'(in_len);
        bus.cfg_out_len = 10'(out_len);
        bus.cfg_shift   = 5'(sh);
        bus.start       = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (n < total + 20) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                bus.start       = 1'b0;
                bus.cfg_in_len  = 10'($urandom);
                bus.cfg_out_len = 10'($urandom);
                bus.cfg_shift   = 5'($urandom);
                chk("busy_after_accept", 64'(bus.busy), 64'(1));
            end
            if (poke && n == 2) begin
                bus.start       = 1'b1;
                bus.cfg_in_len  = 10'($urandom_range(1, 9));
                bus.cfg_out_len = 10'($urandom_range(1, 9));
            end
            if (poke && n == 3) bus.start = 1'b0;
            if (abort_at != 0 && n == abort_at) begin
                rst = 1'b1;
                #1;
                check_zero("abort");
                exp_wr.delete();
                exp_rd.delete();
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag("done_timeout");
        else begin
            chk("done_latency", 64'(n), 64'(total));
            chk("busy_at_done", 64'(bus.busy), 64'(1));
        end
        @(posedge clk);
        #1;
        chk("done_one_cycle", 64'(bus.done), 64'(0));
        chk("busy_cleared",   64'(bus.busy), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("pending_writes", 64'(exp_wr.size()), 64'(0));
        chk("pending_reads",  64'(exp_rd.size()), 64'(0));
    endtask

    task automatic randomize_data(input int in_len, input int out_len);
        int m;
        m = ($urandom_range(0, 3) == 0) ? 30000 : 200;
        for (int e = 0; e < in_len; e++) xv[e] = int'($urandom_range(0, 2*m)) - m;
        for (int n = 0; n < out_len; n++)
            for (int e = 0; e < in_len; e++) wv[n][e] = int'($urandom_range(0, 2*m)) - m;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.cfg_in_len  = '0;
        bus.cfg_out_len = '0;
        bus.cfg_shift   = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic tile: lane l weights l+1, x = 1..4.
        for (int e = 0; e < 4; e++) begin
            xv[e] = e + 1;
            for (int l = 0; l < NL; l++) wv[l][e] = l + 1;
        end
        run(4, 4, 0, 0, 1'b0);

        // Partial second tile, with an ignored start while busy.
        for (int e = 0; e < 4; e++) wv[4][e] = e + 5;
        run(4, 5, 0, 0, 1'b1);

        // Rounding at shift 2: accumulators 6, -6, 18, -18.
        xv[0] = 6;
        wv[0][0] = 1; wv[1][0] = -1; wv[2][0] = 3; wv[3][0] = -3;
        run(1, 4, 2, 0, 1'b0);

        // Saturation: accumulators +/-70000 at shift 0.
        xv[0] = 250; xv[1] = 250;
        wv[0][0] = 140;  wv[0][1] = 140;
        wv[1][0] = -140; wv[1][1] = -140;
        wv[2][0] = 1;    wv[2][1] = -2;
        wv[3][0] = 7;    wv[3][1] = 0;
        run(2, 4, 0, 0, 1'b0);

        // Zero-length runs: immediate done, no bus traffic.
        run(0, 4, 0, 0, 1'b0);
        run(4, 0, 0, 0, 1'b0);

        // Negative accumulator on lane 0 (clamped only with ReLU).
        for (int e = 0; e < 4; e++) begin
            xv[e] = 1;
            wv[0][e] = -3; wv[1][e] = 2; wv[2][e] = -1; wv[3][e] = 5;
        end
        run(4, 4, 0, 0, 1'b0);

        // Abort mid-FETCH, then the same job from scratch.
        randomize_data(8, 8);
        run(8, 8, 1, 3, 1'b0);
        @(posedge clk);
        #1;
        run(8, 8, 1, 0, 1'b0);

        for (int k = 0; k < 14; k++) begin
            int il, ol, sh;
            il = int'($urandom_range(1, MAXE));
            ol = int'($urandom_range(1, MAXN));
            sh = int'($urandom_range(0, 20));
            randomize_data(il, ol);
            run(il, ol, sh, 0, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
